cordic_arbiter: RTL and testbench

Shares one fixed-latency, fully pipelined CORDIC unit between two requesters (e.g. two custom-instruction ports) using round-robin arbitration. It registers the granted operand onto the CORDIC's 32-bit float input and tracks the owner of every in-flight operation with a tag shift register. It steers each result into a per-requester response FIFO, and uses credits so that a FIFO can never overflow. Instantiated directly in front of the CORDIC core, with `cordic_dataa`/`cordic_result` wired to the core's `dataa`/`result`.

---
 rtl/cordic_arbiter_if.sv | 39 +++
 rtl/cordic_arbiter.sv | 113 +++++++++++
 tb/tb_cordic_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_arbiter_if.sv
// Handshake bundle between two requesters, their response ports, and the shared CORDIC core.
// The master side is the environment (requesters, consumers, core); the slave side is the arbiter.
interface cordic_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;

    logic [31:0] cordic_dataa;
    logic [31:0] cordic_result;
    logic        busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        output rsp0_ready, rsp1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  cordic_dataa, busy,
        output cordic_result
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        input  rsp0_ready, rsp1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output cordic_dataa, busy,
        input  cordic_result
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined CORDIC between two requesters,
// with owner tags tracking in-flight operations and credit-protected response FIFOs.
module cordic_arbiter #(
    parameter int LATENCY   = 16,
    parameter int RSP_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    cordic_arbiter_if.slave bus
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    logic [1:0]          req_valid, rsp_ready, eligible, grant, push, pop;
    logic [1:0][31:0]    req_data;
    logic                issue, issue_id;
    logic [1:0][CW-1:0]  out_q, out_d, cnt_q, cnt_d;
    logic [1:0][PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]         mem_q [2][RSP_DEPTH];
    // Stage 0 sits beside cordic_dataa; stages 1..LATENCY mirror the core pipeline.
    tag_t [LATENCY:0]    tag_q, tag_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic [31:0]         dataa_q, dataa_d;

    // NOTE: always_comb uses blocking assignments and gives every output a default
    // first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        req_valid   = {bus.req1_valid, bus.req0_valid};
        rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
        req_data[0] = bus.req0_data;
        req_data[1] = bus.req1_data;

        for (int n = 0; n < 2; n++) begin
            eligible[n] = req_valid[n] && ((out_q[n] + cnt_q[n]) < CW'(RSP_DEPTH));
            pop[n]      = (cnt_q[n] != '0) && rsp_ready[n];
            push[n]     = tag_q[LATENCY].valid && (tag_q[LATENCY].id == 1'(n));
        end

        if (eligible == 2'b11) grant = last_q ? 2'b01 : 2'b10;
        else                   grant = eligible;
        issue    = |grant;
        issue_id = grant[1];

        last_d        = issue ? issue_id : last_q;
        dataa_d       = issue ? req_data[issue_id] : '0;
        tag_d[0].valid = issue;
        tag_d[0].id    = issue_id;
        for (int i = 1; i <= LATENCY; i++) tag_d[i] = tag_q[i-1];

        for (int n = 0; n < 2; n++) begin
            out_d[n]    = out_q[n] + CW'(grant[n]) - CW'(push[n]);
            cnt_d[n]    = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
            wr_ptr_d[n] = wr_ptr_q[n] + PW'(push[n]);
            rd_ptr_d[n] = rd_ptr_q[n] + PW'(pop[n]);
        end

        busy_d = (cnt_d[0] != '0) || (cnt_d[1] != '0);
        for (int i = 0; i <= LATENCY; i++) busy_d = busy_d | tag_d[i].valid;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            dataa_q  <= '0;
        end else begin
            tag_q    <= tag_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            dataa_q  <= dataa_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; cnt_q gates every read,
    // so stale words are never visible.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) mem_q[n][wr_ptr_q[n]] <= bus.cordic_result;
        end
    end

    // rst only gates outputs here, keeping it out of every flop data path.
    assign bus.req0_ready   = grant[0] & rst;
    assign bus.req1_ready   = grant[1] & rst;
    assign bus.rsp0_valid   = (cnt_q[0] != '0);
    assign bus.rsp1_valid   = (cnt_q[1] != '0);
    assign bus.rsp0_data    = (cnt_q[0] != '0) ? mem_q[0][rd_ptr_q[0]] : '0;
    assign bus.rsp1_data    = (cnt_q[1] != '0) ? mem_q[1][rd_ptr_q[1]] : '0;
    assign bus.cordic_dataa = dataa_q;
    assign bus.busy         = busy_q;

    a_no_overflow0: assert property (@(posedge clk) disable iff (!rst)
        !(push[0] && !pop[0] && (cnt_q[0] == CW'(RSP_DEPTH))));
    a_no_overflow1: assert property (@(posedge clk) disable iff (!rst)
        !(push[1] && !pop[1] && (cnt_q[1] == CW'(RSP_DEPTH))));
endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of credits, arbitration and responses.
module tb_cordic_arbiter;
    localparam int L = 16;
    localparam int D = 4;

    typedef struct {
        logic [31:0] data;
        int          arrive;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_arbiter_if bus ();
    cordic_arbiter #(.LATENCY(L), .RSP_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Stand-in transfer function for the CORDIC core; only latency and identity matter here.
    function automatic logic [31:0] cordic_fn(input logic [31:0] x);
        return {x[7:0], x[31:8]} ^ 32'h9E37_79B9;
    endfunction

    logic [31:0] cpipe [L] = '{default: '0};
    always @(posedge clk) begin
        cpipe[0] <= bus.cordic_dataa;
        for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end
    assign bus.cordic_result = cordic_fn(cpipe[L-1]);

    rsp_t        q0[$];
    rsp_t        q1[$];
    logic        m_last  = 1'b1;
    logic [31:0] m_dataa = '0;
    int          edge_n  = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_cnt [2];
    int          rsp_hi [2];
    int          first_rsp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic clear_stats();
        for (int n = 0; n < 2; n++) begin
            acc_cnt[n]   = 0;
            rsp_hi[n]    = 0;
            first_rsp[n] = -1;
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1,
                         input logic [31:0] d1, input logic r0, input logic r1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.rsp0_ready = r0;
        bus.rsp1_ready = r1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        logic [1:0]  vld, rdy, elig, gnt, vis;
        logic [31:0] dat [2];
        logic [31:0] hd [2];
        int          sz [2];
        rsp_t        r;
        @(negedge clk);
        #1;
        if (!rst) begin
            q0.delete();
            q1.delete();
            m_last  = 1'b1;
            m_dataa = '0;
        end
        vld    = {bus.req1_valid, bus.req0_valid};
        rdy    = {bus.rsp1_ready, bus.rsp0_ready};
        dat[0] = bus.req0_data;
        dat[1] = bus.req1_data;
        sz[0]  = q0.size();
        sz[1]  = q1.size();
        vis    = '0;
        hd[0]  = '0;
        hd[1]  = '0;
        if (sz[0] > 0 && q0[0].arrive <= edge_n) begin vis[0] = 1'b1; hd[0] = q0[0].data; end
        if (sz[1] > 0 && q1[0].arrive <= edge_n) begin vis[1] = 1'b1; hd[1] = q1[0].data; end
        for (int n = 0; n < 2; n++) elig[n] = rst && vld[n] && (sz[n] < D);
        gnt = (elig == 2'b11) ? (m_last ? 2'b01 : 2'b10) : elig;

        check("req0_ready", 32'(bus.req0_ready), 32'(gnt[0]));
        check("req1_ready", 32'(bus.req1_ready), 32'(gnt[1]));
        check("rsp0_valid", 32'(bus.rsp0_valid), 32'(vis[0]));
        check("rsp1_valid", 32'(bus.rsp1_valid), 32'(vis[1]));
        check("rsp0_data", bus.rsp0_data, hd[0]);
        check("rsp1_data", bus.rsp1_data, hd[1]);
        check("busy", 32'(bus.busy), 32'((sz[0] + sz[1]) != 0));
        check("cordic_dataa", bus.cordic_dataa, m_dataa);

        if (bus.req0_valid && bus.req0_ready) acc_cnt[0]++;
        if (bus.req1_valid && bus.req1_ready) acc_cnt[1]++;
        if (bus.rsp0_valid) begin rsp_hi[0]++; if (first_rsp[0] < 0) first_rsp[0] = edge_n; end
        if (bus.rsp1_valid) begin rsp_hi[1]++; if (first_rsp[1] < 0) first_rsp[1] = edge_n; end

        @(posedge clk);
        if (rst) begin
            if (vis[0] && rdy[0]) void'(q0.pop_front());
            if (vis[1] && rdy[1]) void'(q1.pop_front());
            r.arrive = edge_n + L + 2;
            if (gnt[0]) begin r.data = cordic_fn(dat[0]); q0.push_back(r); end
            if (gnt[1]) begin r.data = cordic_fn(dat[1]); q1.push_back(r); end
            m_dataa = gnt[0] ? dat[0] : (gnt[1] ? dat[1] : 32'h0);
            if (|gnt) m_last = gnt[1];
            edge_n++;
        end
        #2;
    endtask

    initial begin
        int acc_e;
        clear_stats();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Reset held with both requesters pushing.
        #1 rst = 1'b0;
        drive(1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b1);
        repeat (4) cycle();
        rst = 1'b1;

        // First tie after release goes to requester 0, then 1.
        drive(1'b1, 32'h1111_0000, 1'b1, 32'h2222_0000, 1'b1, 1'b1);
        cycle();
        cycle();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + 6) cycle();

        // Single operation latency and one-cycle response pulse.
        clear_stats();
        drive(1'b1, 32'hBF06_0A92, 1'b0, '0, 1'b1, 1'b1);
        cycle();
        acc_e = edge_n;
        check("single_accept", 32'(acc_cnt[0]), 32'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + 6) cycle();
        check("single_latency", 32'(first_rsp[0] - acc_e), 32'(L + 1));
        check("single_pulse", 32'(rsp_hi[0]), 32'd1);
        check("single_rsp1_quiet", 32'(rsp_hi[1]), 32'd0);

        // Contention: alternating grants, four responses each.
        clear_stats();
        drive(1'b1, 32'h3E86_0A92, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        repeat (8) cycle();
        check("contend_acc0", 32'(acc_cnt[0]), 32'd4);
        check("contend_acc1", 32'(acc_cnt[1]), 32'd4);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + 8) cycle();
        check("contend_rsp0", 32'(rsp_hi[0]), 32'd4);
        check("contend_rsp1", 32'(rsp_hi[1]), 32'd4);

        // Backpressure on response 0: credits stop requester 0 at four.
        clear_stats();
        repeat (30) begin
            drive(1'b1, $urandom, 1'b1, $urandom, 1'b0, 1'b1);
            cycle();
        end
        check("bp_acc0_limit", 32'(acc_cnt[0]), 32'd4);
        check("bp_req1_progress", 32'(acc_cnt[1] > 4), 32'd1);
        repeat (40) begin
            drive(1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b1);
            cycle();
        end
        check("bp_resume", 32'(acc_cnt[0] > 4), 32'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + 8) cycle();

        // Mid-flight reset discards everything in flight.
        clear_stats();
        for (int i = 0; i < 20 && (acc_cnt[0] + acc_cnt[1]) < 5; i++) begin
            drive(1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b1);
            cycle();
        end
        check("midrst_issued", 32'(acc_cnt[0] + acc_cnt[1]), 32'd5);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        clear_stats();
        repeat (L + 6) cycle();
        check("midrst_no_stale", 32'(rsp_hi[0] + rsp_hi[1]), 32'd0);
        drive(1'b0, '0, 1'b1, 32'h4049_0FDB, 1'b1, 1'b1);
        cycle();
        acc_e = edge_n;
        check("midrst_new_accept", 32'(acc_cnt[1]), 32'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + 6) cycle();
        check("midrst_new_latency", 32'(first_rsp[1] - acc_e), 32'(L + 1));

        // Random traffic, including pushes and pops of the same FIFO on one edge.
        repeat (1500) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        repeat (L + D + 10) cycle();
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
